// File: rtl/dff_serial_tx_if.sv
// Word-in / bit-out link between a word producer and a serial transmitter.
// The master side drives the word handshake; the slave side drives the serial strobes.
interface dff_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             ser_dout;
    logic             ser_ena;
    logic             ser_last;
    logic             busy;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, ser_dout, ser_ena, ser_last, busy
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, ser_dout, ser_ena, ser_last, busy
    );
endinterface

// File: rtl/dff_serial_tx.sv
// Parallel-to-serial transmitter: takes a word over valid/ready and emits it LSB first
// with a one-cycle ser_ena strobe per bit and ser_last on the final bit.
module dff_serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic            clk,
    input  logic            rst,
    dff_serial_tx_if.slave  bus
);
    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BIT_PENULT = BW'(WIDTH - 2);
    localparam logic [7:0]    PER_LAST   = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    GAP_LAST   = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bit_cnt;
    logic [7:0]       per_cnt;
    logic             dout_q;
    logic             ena_q;
    logic             last_q;

    assign bus.tx_ready = (state == S_IDLE) && !rst;
    assign bus.busy     = (state != S_IDLE);
    assign bus.ser_dout = dout_q;
    assign bus.ser_ena  = ena_q;
    assign bus.ser_last = last_q;

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift register is cleared along with control state so the
            // datapath never carries an unknown word out of reset.
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            per_cnt <= '0;
            dout_q  <= 1'b0;
            ena_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            ena_q  <= 1'b0;
            last_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        dout_q  <= bus.tx_data[0];
                        shreg   <= bus.tx_data >> 1;
                        ena_q   <= 1'b1;
                        bit_cnt <= '0;
                        per_cnt <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (per_cnt == PER_LAST) begin
                        per_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            dout_q  <= shreg[0];
                            shreg   <= shreg >> 1;
                            ena_q   <= 1'b1;
                            last_q  <= (bit_cnt == BIT_PENULT);
                        end
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (per_cnt == GAP_LAST) begin
                        per_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dff_serial_tx.sv
// Bench for dff_serial_tx: two instances (default pacing and 3 clocks/bit with no gap),
// a per-cycle timing model derived from the bit schedule, directed vectors and random traffic.
module tb_dff_serial_tx;
    localparam int W    = 8;
    localparam int CPB0 = 1;
    localparam int GAP0 = 1;
    localparam int CPB1 = 3;
    localparam int GAP1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dff_serial_tx_if #(.WIDTH(W)) b0 ();
    dff_serial_tx_if #(.WIDTH(W)) b1 ();

    dff_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB0), .GAP_CYCLES(GAP0)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );
    dff_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB1), .GAP_CYCLES(GAP1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: after a transfer at edge k, bit i is presented at cycles
    // k + i*CPB .. k + (i+1)*CPB - 1 with a strobe on the first, and the block is idle
    // again from cycle k + W*CPB + GAP.
    int         cyc = 0;
    bit         armed = 1'b0;
    bit         m_active [2];
    int         m_xfer   [2];
    logic [7:0] m_word   [2];
    logic       m_dout   [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [7:0] o_data [2];
        logic       o_valid [2];
        logic       o_ready [2];
        logic       o_dout [2];
        logic       o_ena [2];
        logic       o_last [2];
        logic       o_busy [2];
        int         cpb, gap, off;
        bit         idle, in_bit, e_ena, e_last, e_ready;
        o_data[0] = b0.tx_data;  o_data[1] = b1.tx_data;
        o_valid[0] = b0.tx_valid; o_valid[1] = b1.tx_valid;
        o_ready[0] = b0.tx_ready; o_ready[1] = b1.tx_ready;
        o_dout[0] = b0.ser_dout; o_dout[1] = b1.ser_dout;
        o_ena[0] = b0.ser_ena;   o_ena[1] = b1.ser_ena;
        o_last[0] = b0.ser_last; o_last[1] = b1.ser_last;
        o_busy[0] = b0.busy;     o_busy[1] = b1.busy;
        for (int i = 0; i < 2; i++) begin
            cpb = (i == 0) ? CPB0 : CPB1;
            gap = (i == 0) ? GAP0 : GAP1;
            e_ready = 1'b0;
            if (armed) begin
                off    = cyc - m_xfer[i];
                idle   = !m_active[i] || (off >= W * cpb + gap);
                in_bit = m_active[i] && (off < W * cpb);
                e_ena  = in_bit && (off % cpb == 0);
                e_last = e_ena && (off / cpb == W - 1);
                if (in_bit) m_dout[i] = m_word[i][off / cpb];
                e_ready = idle && !rst;
                check($sformatf("model_ena%0d", i),   32'(o_ena[i]),   32'(e_ena));
                check($sformatf("model_last%0d", i),  32'(o_last[i]),  32'(e_last));
                check($sformatf("model_dout%0d", i),  32'(o_dout[i]),  32'(m_dout[i]));
                check($sformatf("model_ready%0d", i), 32'(o_ready[i]), 32'(e_ready));
                check($sformatf("model_busy%0d", i),  32'(o_busy[i]),  32'(!idle));
            end
            if (rst) begin
                m_active[i] = 1'b0;
                m_dout[i]   = 1'b0;
            end else if (e_ready && o_valid[i]) begin
                m_active[i] = 1'b1;
                m_xfer[i]   = cyc + 1;
                m_word[i]   = o_data[i];
            end
        end
        if (rst) armed = 1'b1;
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] seq;   // expected serial bits, first transmitted bit in [7]
    } vec_t;

    vec_t vecs [4];

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            if (b0.tx_ready && b1.tx_ready) ok = 1'b1;
            else tick();
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mask, exp_mask, trace, exp_trace;
        logic [7:0]  seq, cap, w;
        logic [7:0]  words [3];
        logic [7:0]  got [$];
        int          n_ena, n_last, last_at, ready_at, n_acc, wi, overlap, n, c;
        bit          acc, drop;

        vecs[0] = '{8'hA5, 8'b10100101};
        vecs[1] = '{8'h01, 8'b10000000};
        vecs[2] = '{8'hF0, 8'b00001111};
        vecs[3] = '{8'h6B, 8'b11010110};

        // Reset with a word pending on both producers
        b0.tx_valid = 1'b1; b0.tx_data = 8'hFF;
        b1.tx_valid = 1'b1; b1.tx_data = 8'hFF;
        repeat (3) begin
            tick();
            check("rst_ready", 32'({b0.tx_ready, b1.tx_ready}), 32'd0);
            check("rst_ena",   32'({b0.ser_ena, b1.ser_ena}), 32'd0);
            check("rst_busy",  32'({b0.busy, b1.busy}), 32'd0);
            check("rst_dout",  32'({b0.ser_dout, b1.ser_dout}), 32'd0);
        end
        rst = 1'b0;
        b0.tx_valid = 1'b0; b1.tx_valid = 1'b0;
        tick();
        check("post_rst_ready", 32'({b0.tx_ready, b1.tx_ready}), 32'b11);

        // Idle: nothing offered for 50 cycles
        n_ena = 0; n = 0; c = 0;
        repeat (50) begin
            tick();
            if (b0.ser_ena || b1.ser_ena) n_ena++;
            if (b0.busy || b1.busy) n++;
            if (!b0.tx_ready || !b1.tx_ready) c++;
        end
        check("idle_ena", 32'(n_ena), 32'd0);
        check("idle_busy", 32'(n), 32'd0);
        check("idle_notready", 32'(c), 32'd0);

        // Table vectors on the default instance
        for (int r = 0; r < 4; r++) begin
            b0.tx_valid = 1'b1; b0.tx_data = vecs[r].data;
            tick();
            b0.tx_valid = 1'b0; b0.tx_data = 8'h00;
            mask = '0; seq = '0; n_ena = 0; last_at = -1; ready_at = -1;
            for (int k = 0; k < 14; k++) begin
                if (b0.ser_ena) begin
                    mask[k] = 1'b1;
                    seq = {seq[6:0], b0.ser_dout};
                    n_ena++;
                    if (b0.ser_last) last_at = n_ena;
                end
                if (b0.tx_ready && ready_at < 0) ready_at = k;
                tick();
            end
            check($sformatf("vec%0d_seq", r), 32'(seq), 32'(vecs[r].seq));
            check($sformatf("vec%0d_ena_mask", r), mask, 32'h00FF);
            check($sformatf("vec%0d_last_at", r), 32'(last_at), 32'd8);
            check($sformatf("vec%0d_reaccept", r), 32'(ready_at + 1), 32'd10);
        end

        // Bit pacing on the 3-clocks-per-bit instance, second word queued behind the first
        w = 8'h3C;
        b1.tx_valid = 1'b1; b1.tx_data = w;
        tick();
        b1.tx_data = 8'h55;
        mask = '0; trace = '0; ready_at = -1; drop = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (b1.ser_ena) mask[k] = 1'b1;
            if (k < 24) trace[k] = b1.ser_dout;
            if (b1.tx_ready && ready_at < 0) ready_at = k;
            acc = b1.tx_ready && b1.tx_valid;
            tick();
            if (acc && !drop) begin b1.tx_valid = 1'b0; drop = 1'b1; end
        end
        exp_mask = (32'd1 << 25) | (32'd1 << 28);
        exp_trace = '0;
        for (int i = 0; i < 8; i++) exp_mask[3 * i] = 1'b1;
        for (int k = 0; k < 24; k++) exp_trace[k] = w[k / 3];
        check("pace_ena_mask", mask, exp_mask);
        check("pace_dout_trace", trace, exp_trace);
        check("pace_reaccept", 32'(ready_at + 1), 32'd25);
        drain("pace_drain");

        // Back-to-back with tx_valid held high
        words[0] = 8'h01; words[1] = 8'h80; words[2] = 8'hFF;
        wi = 0; n_acc = 0; n_ena = 0; n_last = 0; overlap = 0; cap = '0;
        got.delete();
        b0.tx_valid = 1'b1; b0.tx_data = words[0];
        for (int k = 0; k < 40; k++) begin
            if (b0.ser_ena) begin
                cap = {b0.ser_dout, cap[7:1]};
                n_ena++;
                if (b0.ser_last) begin n_last++; got.push_back(cap); end
            end
            if (b0.tx_ready && b0.busy) overlap++;
            acc = b0.tx_ready && b0.tx_valid;
            tick();
            if (acc) begin
                n_acc++; wi++;
                if (wi < 3) b0.tx_data = words[wi];
                else b0.tx_valid = 1'b0;
            end
        end
        check("b2b_ena_count", 32'(n_ena), 32'd24);
        check("b2b_last_count", 32'(n_last), 32'd3);
        check("b2b_accepts", 32'(n_acc), 32'd3);
        check("b2b_ready_busy_overlap", 32'(overlap), 32'd0);
        check("b2b_captured", 32'(got.size()), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++)
            check($sformatf("b2b_word%0d", i), 32'(got[i]), 32'(words[i]));
        drain("b2b_drain");

        // Reset after the 4th strobe of a word
        b0.tx_valid = 1'b1; b0.tx_data = 8'hF0;
        tick();
        b0.tx_valid = 1'b0;
        n = 0; c = 0;
        while (n < 4 && c < 20) begin
            if (b0.ser_ena) n++;
            if (n < 4) begin tick(); c++; end
        end
        check("mid_reached_4th", 32'(n), 32'd4);
        rst = 1'b1;
        n_ena = 0;
        tick(); if (b0.ser_ena) n_ena++;
        tick(); if (b0.ser_ena) n_ena++;
        rst = 1'b0;
        repeat (10) begin tick(); if (b0.ser_ena) n_ena++; end
        check("mid_no_more_ena", 32'(n_ena), 32'd0);
        check("mid_idle_after", 32'({b0.busy, b0.tx_ready}), 32'b01);
        b0.tx_valid = 1'b1; b0.tx_data = 8'h0F;
        tick();
        b0.tx_valid = 1'b0;
        mask = '0; cap = '0;
        for (int k = 0; k < 12; k++) begin
            if (b0.ser_ena) begin mask[k] = 1'b1; cap = {b0.ser_dout, cap[7:1]}; end
            tick();
        end
        check("mid_next_mask", mask, 32'h00FF);
        check("mid_next_word", 32'(cap), 32'h0F);

        // Random traffic with occasional resets, checked by the model
        for (int k = 0; k < 2000; k++) begin
            b0.tx_valid = ($urandom_range(0, 2) != 0);
            b0.tx_data  = 8'($urandom);
            b1.tx_valid = ($urandom_range(0, 2) != 0);
            b1.tx_data  = 8'($urandom);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 1'b0;
        b0.tx_valid = 1'b0; b1.tx_valid = 1'b0;
        drain("rand_drain");
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dff_serial_tx.md
Name: dff_serial_tx

Overview:
- Parallel-to-serial transmitter: the driving end of a single-bit enabled-capture link (din/ena style) into a capturing flip-flop or shift register.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it LSB first on ser_dout.
- Marks each bit with a one-cycle ser_ena strobe and flags the final bit with ser_last.
- Sits between a word-level producer (sequencer-driven stimulus or upstream logic) and the bit-level capture side.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- CLKS_PER_BIT, 1: clock cycles per serial bit period; legal range 1..255.
- GAP_CYCLES, 1: idle cycles inserted after the last bit period before the next word is accepted; legal range 0..255.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous reset, active high.
- tx_data  input  WIDTH  word to transmit; sampled on handshake.
- tx_valid  input  1  producer has a word.
- tx_ready  output  1  block can accept a word this cycle.
- ser_dout  output  1  serial data bit, registered.
- ser_ena  output  1  bit strobe, registered; the capture side samples ser_dout when this is high.
- ser_last  output  1  high together with ser_ena on bit WIDTH-1 only.
- busy  output  1  high in SHIFT and GAP states.

Behaviour:
- Reset, sampled at a clk rising edge while rst=1:
  - state becomes IDLE; shift register, bit counter and period counter clear.
  - ser_dout=0, ser_ena=0, ser_last=0, busy=0.
  - tx_ready=0 while rst=1; tx_ready=1 in the first cycle after rst deasserts.
- rst overrides everything, including mid-word: the word in flight is dropped and no further ser_ena is emitted.
- tx_ready = (state==IDLE) && !rst. It is combinational from state, with no dependence on tx_valid.
- Handshake: transfer occurs at an edge where tx_valid && tx_ready. tx_data is latched into the shift register and state goes to SHIFT.
  - tx_valid without tx_ready has no effect.
  - tx_data is don't-care outside the transfer edge.
- States:
  - IDLE: ser_ena=0, ser_last=0, busy=0. ser_dout holds its last driven value (0 after reset).
  - SHIFT: for bit i = 0..WIDTH-1, LSB first:
    - ser_dout = tx_data[i], held for CLKS_PER_BIT cycles.
    - ser_ena=1 only in the first cycle of each bit period.
    - ser_last=1 in that same cycle for i=WIDTH-1.
  - At the end of the last bit period: go to GAP if GAP_CYCLES>0, else to IDLE.
  - GAP: counts GAP_CYCLES cycles with ser_ena=0, then goes to IDLE.
- Latency: transfer at edge k; the first ser_ena is high in the cycle after edge k (registered outputs).
- Throughput: WIDTH*CLKS_PER_BIT + GAP_CYCLES + 1 cycles per word minimum; the +1 is the IDLE acceptance cycle. No back-to-back overlap.
- Counters:
  - Bit counter width is clog2(WIDTH).
  - Period counter width is 8 bits.
  - Both wrap to 0 at their terminal value and never overflow.
- Exactly WIDTH ser_ena pulses occur per accepted word, and exactly one ser_last.
- A capture-side register with din=ser_dout and ena=ser_ena, shifting right from the MSB, reconstructs tx_data after the ser_last strobe.

Test Plan:
- Reset check: rst=1 for 3 cycles, with tx_valid=1 and tx_data=8'hFF, then rst=0 -> during reset tx_ready=0, ser_ena=0, busy=0, ser_dout=0; tx_ready=1 on the first post-reset cycle.
- Single word, defaults (WIDTH=8, CLKS_PER_BIT=1, GAP_CYCLES=1): send 8'hA5 -> ser_ena high for 8 consecutive cycles starting the cycle after the transfer; ser_dout sequence 1,0,1,0,0,1,0,1; ser_last on the 8th; tx_ready returns 10 cycles after the transfer edge.
- Bit pacing (CLKS_PER_BIT=3, GAP_CYCLES=0): send 8'h3C -> ser_ena pulses every 3rd cycle, 8 pulses total; ser_dout stable for 3 cycles per bit; next word accepted 25 cycles after the first transfer.
- Back-to-back with tx_valid held high: words 8'h01, 8'h80, 8'hFF -> captured sequence equals the sent words in order; exactly 24 ser_ena and 3 ser_last pulses; no extra accept occurs while busy=1.
- Reset mid-word: assert rst after the 4th ser_ena of 8'hF0 -> no further ser_ena; the next word 8'h0F after reset transmits correctly with 8 pulses.
- Idle stimulus: tx_valid=0 for 50 cycles -> ser_ena never asserts; busy=0; tx_ready=1 throughout.
